// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word requests, buffers responses for the decoder.
// Latency: a response in cycle N is presented to the decoder in cycle N+1; one instruction per cycle sustained.
// Backpressure: requests only issue while a FIFO slot is guaranteed; decoder stalls hold the head entry.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_data_o,
  output logic [31:0] instr_pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [31:0]   buf_data [FIFO_DEPTH];
  logic [31:0]   buf_pc   [FIFO_DEPTH];

  logic          req_valid;
  logic          req_fire;
  logic          rsp_fire;
  logic          push;
  logic          pop;
  logic          instr_valid;
  logic          credit_ok;
  logic [CW:0]   used;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] count_next;
  logic [31:0]   redirect_addr;

  // Low two bits of the redirect target are dropped; masking keeps every input bit referenced.
  assign redirect_addr = redirect_pc_i & ~32'h0000_0003;

  assign instr_valid = (count != '0);

  // A pop in a redirect cycle is swallowed by the flush, so it never counts as a consume.
  assign pop = instr_valid & instr_ready_i & ~redirect_i;

  // Slots committed = in-flight requests + buffered words; a same-cycle pop frees its slot
  // immediately, which is what lets a 1-cycle memory stream at one word per cycle.
  assign used      = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
  assign credit_ok = (used < DEPTH_EXT);

  assign req_fire = req_valid & imem_req_ready_i;

  // Responses with nothing outstanding are a protocol error and are ignored.
  assign rsp_fire = imem_rsp_valid_i & (outstanding != '0);

  // Words still owed to a flushed stream are dropped; the redirect cycle itself never pushes.
  assign push = rsp_fire & (discard == '0) & ~redirect_i;

  assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);
  assign count_next       = count + CW'(push) - CW'(pop);

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and request-valid decode; no request while idle after reset or while redirecting.
  always_comb begin
    state_next = state;
    req_valid  = 1'b0;
    case (state)
      ST_RESET: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        req_valid = credit_ok & ~redirect_i;
      end
      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

  // PC, credit and FIFO bookkeeping; a redirect restarts both PCs and hands every
  // in-flight request (including one accepted this cycle) to the discard counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (state == ST_RESET) begin
      if (redirect_i) begin
        fetch_pc <= redirect_addr;
        rsp_pc   <= redirect_addr;
      end
    end else if (redirect_i) begin
      fetch_pc    <= redirect_addr;
      rsp_pc      <= redirect_addr;
      outstanding <= outstanding_next;
      discard     <= outstanding_next;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding_next;
      count       <= count_next;
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (rsp_fire && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
      if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Buffer storage; cleared on reset so the decoder-facing outputs read zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (push) begin
      buf_data[wr_ptr] <= imem_rsp_data_i;
      buf_pc[wr_ptr]   <= rsp_pc;
    end
  end

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = fetch_pc;
  assign instr_valid_o    = instr_valid;
  assign instr_data_o     = buf_data[rd_ptr];
  assign instr_pc_o       = buf_pc[rd_ptr];

  // Memory must never answer more requests than were issued.
  a_rsp_expected : assert property (@(posedge clk_i) disable iff (!rstn_i)
    imem_rsp_valid_i |-> (outstanding != '0));

  // The credit scheme keeps the buffer and the in-flight count within depth.
  a_count_bound : assert property (@(posedge clk_i) disable iff (!rstn_i)
    (count <= DEPTH_CNT) && (outstanding <= DEPTH_CNT));

endmodule
